// File: rtl/bp_l15_req_arbiter_if.sv
// Signal bundle between two request sources, the L1.5 request/return channels
// and the response consumer. The master view belongs to the arbiter.
interface bp_l15_req_arbiter_if #(
   parameter int paddr_width_p = 40
);
   logic                     r0_v_i;
   logic [4:0]               r0_rqtype_i;
   logic [2:0]               r0_size_i;
   logic                     r0_nc_i;
   logic [paddr_width_p-1:0] r0_addr_i;
   logic [63:0]              r0_data_i;
   logic                     r0_yumi_o;

   logic                     r1_v_i;
   logic [4:0]               r1_rqtype_i;
   logic [2:0]               r1_size_i;
   logic                     r1_nc_i;
   logic [paddr_width_p-1:0] r1_addr_i;
   logic [63:0]              r1_data_i;
   logic                     r1_yumi_o;

   logic                     transducer_l15_val;
   logic [4:0]               transducer_l15_rqtype;
   logic [2:0]               transducer_l15_size;
   logic [paddr_width_p-1:0] transducer_l15_address;
   logic [63:0]              transducer_l15_data;
   logic                     transducer_l15_nc;
   logic                     l15_transducer_ack;
   logic                     l15_transducer_header_ack;

   logic                     l15_transducer_val;
   logic [3:0]               l15_transducer_returntype;
   logic [63:0]              l15_transducer_data_0;
   logic [63:0]              l15_transducer_data_1;
   logic                     transducer_l15_req_ack;

   logic                     resp_v_o;
   logic                     resp_owner_o;
   logic [3:0]               resp_returntype_o;
   logic [127:0]             resp_data_o;
   logic                     resp_ready_i;

   logic                     busy_o;
   logic                     timeout_o;
   logic                     unsolicited_o;

   modport master (
      input  r0_v_i, r0_rqtype_i, r0_size_i, r0_nc_i, r0_addr_i, r0_data_i,
      input  r1_v_i, r1_rqtype_i, r1_size_i, r1_nc_i, r1_addr_i, r1_data_i,
      output r0_yumi_o, r1_yumi_o,
      output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
      output transducer_l15_address, transducer_l15_data, transducer_l15_nc,
      input  l15_transducer_ack, l15_transducer_header_ack,
      input  l15_transducer_val, l15_transducer_returntype,
      input  l15_transducer_data_0, l15_transducer_data_1,
      output transducer_l15_req_ack,
      output resp_v_o, resp_owner_o, resp_returntype_o, resp_data_o,
      input  resp_ready_i,
      output busy_o, timeout_o, unsolicited_o
   );

   modport slave (
      output r0_v_i, r0_rqtype_i, r0_size_i, r0_nc_i, r0_addr_i, r0_data_i,
      output r1_v_i, r1_rqtype_i, r1_size_i, r1_nc_i, r1_addr_i, r1_data_i,
      input  r0_yumi_o, r1_yumi_o,
      input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
      input  transducer_l15_address, transducer_l15_data, transducer_l15_nc,
      output l15_transducer_ack, l15_transducer_header_ack,
      output l15_transducer_val, l15_transducer_returntype,
      output l15_transducer_data_0, l15_transducer_data_1,
      input  transducer_l15_req_ack,
      input  resp_v_o, resp_owner_o, resp_returntype_o, resp_data_o,
      output resp_ready_i,
      input  busy_o, timeout_o, unsolicited_o
   );
endinterface

// File: rtl/bp_l15_req_arbiter.sv
// Round-robin arbiter funnelling two requesters onto one L1.5 request channel,
// one transaction in flight, with response routing back to the owner.
module bp_l15_req_arbiter #(
   parameter int paddr_width_p = 40,
   parameter int timeout_p     = 1024
) (
   input logic                  clk_i,
   input logic                  reset_i,
   bp_l15_req_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

   localparam logic [15:0] TIMEOUT_C = 16'(timeout_p);

   state_e                   state_q, state_d;
   logic                     last_grant_q, last_grant_d;
   logic                     owner_q, owner_d;
   logic [4:0]               rqtype_q, rqtype_d;
   logic [2:0]               size_q, size_d;
   logic                     nc_q, nc_d;
   logic [paddr_width_p-1:0] addr_q, addr_d;
   logic [63:0]              data_q, data_d;
   logic [3:0]               ret_type_q, ret_type_d;
   logic [127:0]             ret_data_q, ret_data_d;
   logic [15:0]              cnt_q, cnt_d;
   logic                     grant_id;
   logic                     yumi0, yumi1;
   logic                     unused_header_ack;

   assign unused_header_ack = bus.l15_transducer_header_ack;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      rqtype_d     = rqtype_q;
      size_d       = size_q;
      nc_d         = nc_q;
      addr_d       = addr_q;
      data_d       = data_q;
      ret_type_d   = ret_type_q;
      ret_data_d   = ret_data_q;
      cnt_d        = cnt_q;
      yumi0        = 1'b0;
      yumi1        = 1'b0;
      // On a tie the requester not served last wins; otherwise the lone valid one.
      grant_id = (bus.r0_v_i & bus.r1_v_i) ? ~last_grant_q : ~bus.r0_v_i;

      unique case (state_q)
         IDLE: begin
            if (bus.r0_v_i | bus.r1_v_i) begin
               state_d      = REQ;
               last_grant_d = grant_id;
               owner_d      = grant_id;
               rqtype_d     = grant_id ? bus.r1_rqtype_i : bus.r0_rqtype_i;
               size_d       = grant_id ? bus.r1_size_i   : bus.r0_size_i;
               nc_d         = grant_id ? bus.r1_nc_i     : bus.r0_nc_i;
               addr_d       = grant_id ? bus.r1_addr_i   : bus.r0_addr_i;
               data_d       = grant_id ? bus.r1_data_i   : bus.r0_data_i;
               yumi0        = ~grant_id;
               yumi1        = grant_id;
            end
         end
         REQ: begin
            if (bus.l15_transducer_ack) begin
               state_d = WAIT;
               cnt_d   = 16'd0;
            end
         end
         WAIT: begin
            if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + 16'd1;
            if (bus.l15_transducer_val) begin
               state_d    = RESP;
               ret_type_d = bus.l15_transducer_returntype;
               ret_data_d = {bus.l15_transducer_data_1, bus.l15_transducer_data_0};
            end
         end
         RESP: begin
            if (bus.resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         rqtype_q     <= '0;
         size_q       <= '0;
         nc_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         ret_type_q   <= '0;
         ret_data_q   <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         rqtype_q     <= rqtype_d;
         size_q       <= size_d;
         nc_q         <= nc_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         ret_type_q   <= ret_type_d;
         ret_data_q   <= ret_data_d;
         cnt_q        <= cnt_d;
      end
   end

   // Paths straight from inputs are masked so outputs sit at rest while reset is high.
   assign bus.r0_yumi_o              = yumi0 & ~reset_i;
   assign bus.r1_yumi_o              = yumi1 & ~reset_i;
   assign bus.transducer_l15_req_ack = bus.l15_transducer_val & ~reset_i;
   assign bus.unsolicited_o          = bus.l15_transducer_val & (state_q != WAIT) & ~reset_i;

   assign bus.transducer_l15_val     = (state_q == REQ);
   assign bus.transducer_l15_rqtype  = rqtype_q;
   assign bus.transducer_l15_size    = size_q;
   assign bus.transducer_l15_address = addr_q;
   assign bus.transducer_l15_data    = data_q;
   assign bus.transducer_l15_nc      = nc_q;

   assign bus.resp_v_o          = (state_q == RESP);
   assign bus.resp_owner_o      = owner_q;
   assign bus.resp_returntype_o = ret_type_q;
   assign bus.resp_data_o       = ret_data_q;

   assign bus.busy_o    = (state_q != IDLE);
   assign bus.timeout_o = (state_q == WAIT) && (cnt_q == TIMEOUT_C - 16'd1);
endmodule

// File: tb/tb_bp_l15_req_arbiter.sv
// Random two-requester traffic against a transaction-level model of the
// arbiter, with a responsive L1.5 stub, stray returns and mid-flight resets.
module tb_bp_l15_req_arbiter;
   localparam int PW = 40;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bp_l15_req_arbiter_if #(.paddr_width_p(PW)) bus ();

   bp_l15_req_arbiter #(.paddr_width_p(PW), .timeout_p(TO)) dut (
      .clk_i  (clk),
      .reset_i(rst),
      .bus    (bus)
   );

   typedef struct {
      logic          owner;
      logic [4:0]    rqtype;
      logic [2:0]    size;
      logic          nc;
      logic [PW-1:0] addr;
      logic [63:0]   data;
      logic [3:0]    rtype;
      logic [127:0]  rdata;
   } txn_t;

   int n_tests = 0;
   int n_fail  = 0;
   int n_txn   = 0;

   // Model: one outstanding transaction and how far it has progressed.
   bit   has_txn, acked, returned;
   bit   tie_winner;
   bit   force_tie;
   int   wait_cycles;
   txn_t t;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      has_txn     = 0;
      acked       = 0;
      returned    = 0;
      tie_winner  = 0;
      wait_cycles = 0;
      force_tie   = 1;
   endtask

   task automatic reset_checks();
      chk("rst_yumi0",     128'(bus.r0_yumi_o), 128'd0);
      chk("rst_yumi1",     128'(bus.r1_yumi_o), 128'd0);
      chk("rst_l15_val",   128'(bus.transducer_l15_val), 128'd0);
      chk("rst_req_ack",   128'(bus.transducer_l15_req_ack), 128'd0);
      chk("rst_resp_v",    128'(bus.resp_v_o), 128'd0);
      chk("rst_timeout",   128'(bus.timeout_o), 128'd0);
      chk("rst_unsol",     128'(bus.unsolicited_o), 128'd0);
      chk("rst_busy",      128'(bus.busy_o), 128'd0);
      chk("rst_l15_addr",  128'(bus.transducer_l15_address), 128'd0);
      chk("rst_l15_data",  128'(bus.transducer_l15_data), 128'd0);
      chk("rst_resp_data", bus.resp_data_o, 128'd0);
   endtask

   task automatic drive_inputs();
      bus.r0_v_i      = force_tie ? 1'b1 : 1'($urandom_range(0, 1));
      bus.r1_v_i      = force_tie ? 1'b1 : 1'($urandom_range(0, 1));
      force_tie       = 0;
      bus.r0_rqtype_i = 5'($urandom);
      bus.r1_rqtype_i = 5'($urandom);
      bus.r0_size_i   = 3'($urandom);
      bus.r1_size_i   = 3'($urandom);
      bus.r0_nc_i     = 1'($urandom);
      bus.r1_nc_i     = 1'($urandom);
      bus.r0_addr_i   = PW'({$urandom, $urandom});
      bus.r1_addr_i   = PW'({$urandom, $urandom});
      bus.r0_data_i   = {$urandom, $urandom};
      bus.r1_data_i   = {$urandom, $urandom};
      bus.l15_transducer_ack = (has_txn && !acked) ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus.l15_transducer_header_ack = 1'($urandom);
      if (has_txn && acked && !returned)
         bus.l15_transducer_val = ($urandom_range(0, 5) == 0);
      else
         bus.l15_transducer_val = ($urandom_range(0, 15) == 0);
      bus.l15_transducer_returntype = 4'($urandom);
      bus.l15_transducer_data_0     = {$urandom, $urandom};
      bus.l15_transducer_data_1     = {$urandom, $urandom};
      bus.resp_ready_i              = ($urandom_range(0, 2) == 0);
   endtask

   task automatic check_and_step();
      bit grant_v, winner, in_wait;
      grant_v = !has_txn && (bus.r0_v_i || bus.r1_v_i);
      if (bus.r0_v_i && bus.r1_v_i) winner = tie_winner;
      else                          winner = bus.r1_v_i;
      in_wait = has_txn && acked && !returned;

      chk("yumi0", 128'(bus.r0_yumi_o), 128'(grant_v && !winner));
      chk("yumi1", 128'(bus.r1_yumi_o), 128'(grant_v && winner));
      chk("l15_val", 128'(bus.transducer_l15_val), 128'(has_txn && !acked));
      if (has_txn && !acked) begin
         chk("l15_addr",   128'(bus.transducer_l15_address), 128'(t.addr));
         chk("l15_rqtype", 128'(bus.transducer_l15_rqtype), 128'(t.rqtype));
         chk("l15_size",   128'(bus.transducer_l15_size), 128'(t.size));
         chk("l15_nc",     128'(bus.transducer_l15_nc), 128'(t.nc));
         chk("l15_data",   128'(bus.transducer_l15_data), 128'(t.data));
      end
      chk("req_ack", 128'(bus.transducer_l15_req_ack), 128'(bus.l15_transducer_val));
      chk("unsolicited", 128'(bus.unsolicited_o), 128'(bus.l15_transducer_val && !in_wait));
      chk("timeout", 128'(bus.timeout_o), 128'(in_wait && wait_cycles == TO - 1));
      chk("busy", 128'(bus.busy_o), 128'(has_txn));
      chk("resp_v", 128'(bus.resp_v_o), 128'(has_txn && returned));
      if (has_txn && returned) begin
         chk("resp_owner", 128'(bus.resp_owner_o), 128'(t.owner));
         chk("resp_rtype", 128'(bus.resp_returntype_o), 128'(t.rtype));
         chk("resp_data",  bus.resp_data_o, t.rdata);
      end

      // Advance the model across the coming clock edge.
      if (grant_v) begin
         has_txn    = 1;
         acked      = 0;
         returned   = 0;
         t.owner    = winner;
         t.rqtype   = winner ? bus.r1_rqtype_i : bus.r0_rqtype_i;
         t.size     = winner ? bus.r1_size_i   : bus.r0_size_i;
         t.nc       = winner ? bus.r1_nc_i     : bus.r0_nc_i;
         t.addr     = winner ? bus.r1_addr_i   : bus.r0_addr_i;
         t.data     = winner ? bus.r1_data_i   : bus.r0_data_i;
         tie_winner = !winner;
      end else if (has_txn && !acked) begin
         if (bus.l15_transducer_ack) begin
            acked       = 1;
            wait_cycles = 0;
         end
      end else if (in_wait) begin
         if (bus.l15_transducer_val) begin
            returned = 1;
            t.rtype  = bus.l15_transducer_returntype;
            t.rdata  = {bus.l15_transducer_data_1, bus.l15_transducer_data_0};
         end
         wait_cycles++;
      end else if (has_txn && returned && bus.resp_ready_i) begin
         n_txn++;
         $display("[TB] txn %0d owner=r%0d addr=%h rqtype=%0d wait=%0d data=%h",
                  n_txn, t.owner, t.addr, t.rqtype, wait_cycles, t.rdata);
         has_txn = 0;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.r0_v_i = 0; bus.r1_v_i = 0;
      bus.r0_rqtype_i = 0; bus.r1_rqtype_i = 0; bus.r0_size_i = 0; bus.r1_size_i = 0;
      bus.r0_nc_i = 0; bus.r1_nc_i = 0; bus.r0_addr_i = 0; bus.r1_addr_i = 0;
      bus.r0_data_i = 0; bus.r1_data_i = 0;
      bus.l15_transducer_ack = 0; bus.l15_transducer_header_ack = 0;
      bus.l15_transducer_val = 0; bus.l15_transducer_returntype = 0;
      bus.l15_transducer_data_0 = 0; bus.l15_transducer_data_1 = 0;
      bus.resp_ready_i = 0;
      model_reset();
      #1 reset_checks();

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         rst = 1'b0;
         drive_inputs();
         if (has_txn && $urandom_range(0, 120) == 0) begin
            // Asynchronous reset in the middle of a transaction, inputs still active.
            rst = 1'b1;
            #1 reset_checks();
            model_reset();
         end else begin
            #2 check_and_step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
